// File: rtl/array_memory_pkg.sv
// Shared definitions for the array heap: operation codes carried on the
// 8-bit action port, the controller state type, and a small decode helper.
package array_memory_pkg;

   typedef logic [7:0] action_t;

   localparam action_t ACT_WRITE   = 8'd2;
   localparam action_t ACT_READ    = 8'd3;
   localparam action_t ACT_SIZE    = 8'd4;
   localparam action_t ACT_PUSH    = 8'd5;
   localparam action_t ACT_POP     = 8'd6;
   localparam action_t ACT_CLEAR   = 8'd7;
   localparam action_t ACT_LESS    = 8'd8;
   localparam action_t ACT_GREATER = 8'd9;

   // IDLE accepts a request. SCAN is the busy state: single-cycle operations
   // complete on their first SCAN cycle, Less/Greater stay one cycle per element.
   typedef enum logic {IDLE, SCAN} state_t;

   function automatic logic is_scan(input action_t a);
      return (a == ACT_LESS) || (a == ACT_GREATER);
   endfunction

endpackage

// File: rtl/array_memory.sv
// array_memory: heap of ARRAYS fixed-capacity arrays of ARRAY_LENGTH elements,
// each with its own fill size, driven by a one-outstanding valid/ready request.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (high only while IDLE)
//   action     in   operation code (array_memory_pkg::ACT_*)
//   array      in   array selected by the request
//   index      in   element index for Read/Write
//   in         in   write/push data or comparison operand
//   out_valid  out  one-cycle pulse marking a new response on out/error
//   out        out  response data, held until the next response
//   error      out  response flags an illegal request, held with out
module array_memory
   import array_memory_pkg::*;
#(
   parameter int ADDRESS_BITS = 8,
   parameter int INDEX_BITS   = 3,
   parameter int DATA_BITS    = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [7:0]              action,
   input  logic [ADDRESS_BITS-1:0] array,
   input  logic [INDEX_BITS-1:0]   index,
   input  logic [DATA_BITS-1:0]    in,
   output logic                    out_valid,
   output logic [DATA_BITS-1:0]    out,
   output logic                    error
);

   localparam int ARRAYS       = 2 ** ADDRESS_BITS;
   localparam int ARRAY_LENGTH = 2 ** INDEX_BITS;

   localparam logic [INDEX_BITS:0] SIZE_ONE  = {{INDEX_BITS{1'b0}}, 1'b1};
   localparam logic [INDEX_BITS:0] SIZE_FULL = {1'b1, {INDEX_BITS{1'b0}}};

   // Controller state and the captured request
   state_t                  state, state_d;
   action_t                 act_q;
   logic [ADDRESS_BITS-1:0] array_q;
   logic [INDEX_BITS-1:0]   index_q;
   logic [DATA_BITS-1:0]    in_q;

   // Scan progress: element under examination and running match count
   logic [INDEX_BITS:0]     scan_idx, scan_idx_d;
   logic [INDEX_BITS:0]     count, count_d;

   // Storage
   logic [INDEX_BITS:0]     size [ARRAYS];
   logic [DATA_BITS-1:0]    mem  [ARRAYS][ARRAY_LENGTH];

   // Datapath between the decode and the registers
   logic [INDEX_BITS:0]     cur_size;
   logic [INDEX_BITS:0]     size_dec;
   logic [INDEX_BITS-1:0]   rd_idx;
   logic [DATA_BITS-1:0]    rd_data;
   logic                    hit;
   logic                    accept;
   logic                    done;
   logic [DATA_BITS-1:0]    out_d;
   logic                    error_d;
   logic                    mem_we;
   logic [INDEX_BITS-1:0]   mem_idx;
   logic                    size_we;
   logic [INDEX_BITS:0]     size_d;

   assign cur_size = size[array_q];
   assign size_dec = cur_size - SIZE_ONE;

   // Single read port shared by Read, Pop and the scan. Out-of-range
   // addresses only occur when the operation is about to report an error,
   // so the returned word is never used in that case.
   always_comb begin
      rd_idx = index_q;
      if (act_q == ACT_POP) begin
         rd_idx = size_dec[INDEX_BITS-1:0];
      end else if (is_scan(act_q)) begin
         rd_idx = scan_idx[INDEX_BITS-1:0];
      end
   end

   assign rd_data = mem[array_q][rd_idx];
   assign hit     = (act_q == ACT_LESS) ? (rd_data < in_q) : (rd_data > in_q);

   // Next-state, response and storage-update decode
   always_comb begin
      // NOTE: every signal driven here gets a default first so no path
      // leaves one unassigned and a latch is never inferred.
      state_d    = state;
      scan_idx_d = scan_idx;
      count_d    = count;
      req_ready  = (state == IDLE);
      accept     = 1'b0;
      done       = 1'b0;
      out_d      = '0;
      error_d    = 1'b0;
      mem_we     = 1'b0;
      mem_idx    = index_q;
      size_we    = 1'b0;
      size_d     = cur_size;

      unique case (state)
         IDLE: begin
            accept = req_valid;
            if (req_valid) begin
               state_d    = SCAN;
               scan_idx_d = '0;
               count_d    = '0;
            end
         end

         SCAN: begin
            done = 1'b1;
            case (act_q)
               ACT_SIZE: begin
                  out_d = DATA_BITS'(cur_size);
               end

               ACT_WRITE: begin
                  if ({1'b0, index_q} < cur_size) begin
                     mem_we = 1'b1;
                     out_d  = in_q;
                  end else begin
                     error_d = 1'b1;
                  end
               end

               ACT_READ: begin
                  if ({1'b0, index_q} < cur_size) begin
                     out_d = rd_data;
                  end else begin
                     error_d = 1'b1;
                  end
               end

               ACT_PUSH: begin
                  if (cur_size < SIZE_FULL) begin
                     mem_we  = 1'b1;
                     mem_idx = cur_size[INDEX_BITS-1:0];
                     size_we = 1'b1;
                     size_d  = cur_size + SIZE_ONE;
                     out_d   = DATA_BITS'(cur_size + SIZE_ONE);
                  end else begin
                     error_d = 1'b1;
                  end
               end

               ACT_POP: begin
                  if (cur_size != '0) begin
                     size_we = 1'b1;
                     size_d  = size_dec;
                     out_d   = rd_data;
                  end else begin
                     error_d = 1'b1;
                  end
               end

               ACT_CLEAR: begin
                  size_we = 1'b1;
                  size_d  = '0;
               end

               ACT_LESS, ACT_GREATER: begin
                  // Examine one element per cycle; the cycle that finds the
                  // index equal to the size reports, so size 0 answers at once.
                  if (scan_idx == cur_size) begin
                     out_d = DATA_BITS'(count);
                  end else begin
                     done       = 1'b0;
                     count_d    = count + {{INDEX_BITS{1'b0}}, hit};
                     scan_idx_d = scan_idx + SIZE_ONE;
                  end
               end

               default: begin
                  error_d = 1'b1;
               end
            endcase

            if (done) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Controller, request capture and response registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         act_q     <= '0;
         array_q   <= '0;
         index_q   <= '0;
         in_q      <= '0;
         scan_idx  <= '0;
         count     <= '0;
         out_valid <= 1'b0;
         out       <= '0;
         error     <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples pre-edge values regardless of statement order.
         state     <= state_d;
         scan_idx  <= scan_idx_d;
         count     <= count_d;
         out_valid <= done;
         if (accept) begin
            act_q   <= action;
            array_q <= array;
            index_q <= index;
            in_q    <= in;
         end
         if (done) begin
            out   <= out_d;
            error <= error_d;
         end
      end
   end

   // Per-array fill sizes; reset empties every array
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int a = 0; a < ARRAYS; a++) begin
            size[a] <= '0;
         end
      end else if (size_we) begin
         size[array_q] <= size_d;
      end
   end

   // NOTE: element storage has no reset so it can map onto RAM; all reads
   // are guarded by the array size, so stale contents are never observed.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[array_q][mem_idx] <= in_q;
      end
   end

endmodule

// File: tb/tb_array_memory.sv
// Self-checking bench for array_memory. A queue-per-array reference model
// predicts every response, its latency and the error flag.
module tb_array_memory;
   import array_memory_pkg::*;

   localparam int AB  = 3;
   localparam int IB  = 2;
   localparam int DB  = 8;
   localparam int NA  = 2 ** AB;
   localparam int LEN = 2 ** IB;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [7:0]    action = '0;
   logic [AB-1:0] array = '0;
   logic [IB-1:0] index = '0;
   logic [DB-1:0] in = '0;
   logic          out_valid;
   logic [DB-1:0] out;
   logic          error;

   int compared   = 0;
   int mismatched = 0;

   int unsigned model_q [NA][$];

   int unsigned last_out;
   bit          last_err;
   int          last_lat;

   array_memory #(
      .ADDRESS_BITS(AB),
      .INDEX_BITS  (IB),
      .DATA_BITS   (DB)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .action   (action),
      .array    (array),
      .index    (index),
      .in       (in),
      .out_valid(out_valid),
      .out      (out),
      .error    (error)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference behaviour: arrays are bounded queues
   task automatic model_exec(input logic [7:0] a, input int arr, input int idx,
                             input int unsigned din, output int unsigned e_out,
                             output bit e_err, output int e_lat);
      int n;
      n     = model_q[arr].size();
      e_out = 0;
      e_err = 1'b0;
      e_lat = 1;
      case (a)
         ACT_SIZE:  e_out = n;
         ACT_WRITE: if (idx < n) begin model_q[arr][idx] = din; e_out = din; end else e_err = 1'b1;
         ACT_READ:  if (idx < n) e_out = model_q[arr][idx]; else e_err = 1'b1;
         ACT_PUSH:  if (n < LEN) begin model_q[arr].push_back(din); e_out = n + 1; end else e_err = 1'b1;
         ACT_POP:   if (n > 0) e_out = model_q[arr].pop_back(); else e_err = 1'b1;
         ACT_CLEAR: model_q[arr].delete();
         ACT_LESS, ACT_GREATER: begin
            e_lat = 1 + n;
            for (int k = 0; k < n; k++) begin
               if (a == ACT_LESS ? (model_q[arr][k] < din) : (model_q[arr][k] > din)) e_out++;
            end
         end
         default:   e_err = 1'b1;
      endcase
   endtask

   // Issue one request (entered just after a falling edge) and wait for its
   // response; busy_ok clears if req_ready is seen high while busy or low at
   // the response.
   task automatic issue(input logic [7:0] a, input int arr, input int idx, input int unsigned din,
                        output int unsigned o, output bit e, output int lat, output bit busy_ok);
      int guard;
      guard   = 0;
      busy_ok = 1'b1;
      while (!req_ready && guard < 64) begin
         @(negedge clock);
         guard++;
      end
      if (!req_ready) busy_ok = 1'b0;
      action    = a;
      array     = arr[AB-1:0];
      index     = idx[IB-1:0];
      in        = din[DB-1:0];
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      lat = 0;
      forever begin
         @(posedge clock);
         #1;
         lat++;
         if (out_valid) begin
            if (!req_ready) busy_ok = 1'b0;
            break;
         end
         if (req_ready) busy_ok = 1'b0;
         if (lat >= 64) break;
      end
      if (!out_valid) lat = -1;
      o = out;
      e = error;
      @(negedge clock);
   endtask

   task automatic run_op(input string tag, input logic [7:0] a, input int arr,
                         input int idx, input int unsigned din);
      int unsigned eo, o;
      bit          ee, e, bo;
      int          el, lat;
      model_exec(a, arr, idx, din % (1 << DB), eo, ee, el);
      issue(a, arr, idx, din, o, e, lat, bo);
      check({tag, ".out"},   o,   eo);
      check({tag, ".err"},   e,   ee);
      check({tag, ".lat"},   lat, el);
      check({tag, ".ready"}, bo,  1);
      last_out = o;
      last_err = e;
      last_lat = lat;
   endtask

   initial begin
      int          seen;
      int unsigned exp_o [$];
      bit          exp_e [$];
      logic [7:0]  b_act [$];
      logic [7:0]  b_arr [$];
      logic [7:0]  b_din [$];
      int          sent, got, cyc;
      bit          acc;

      // Reset state
      #2 reset = 1'b1;
      #1;
      check("rst.ready", req_ready, 1);
      check("rst.valid", out_valid, 0);
      check("rst.out",   out,       0);
      check("rst.error", error,     0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Size of empty arrays
      run_op("t1.size0", ACT_SIZE, 0, 0, 0);
      run_op("t1.size3", ACT_SIZE, 3, 0, 0);
      check("t1.size3.lit", last_out, 0);

      // Push until full, overflow, then pop back to empty
      run_op("t2.push5", ACT_PUSH, 1, 0, 5);
      check("t2.push5.lit", last_out, 1);
      run_op("t2.push7", ACT_PUSH, 1, 0, 7);
      check("t2.push7.lit", last_out, 2);
      run_op("t2.push8", ACT_PUSH, 1, 0, 8);
      run_op("t2.push9", ACT_PUSH, 1, 0, 9);
      check("t2.full.lit", last_out, LEN);
      run_op("t2.pushx", ACT_PUSH, 1, 0, 11);
      check("t2.pushx.lit", last_err, 1);
      run_op("t2.size", ACT_SIZE, 1, 0, 0);
      for (int k = 0; k < LEN; k++) run_op("t2.pop", ACT_POP, 1, 0, 0);
      check("t2.pop5.lit", last_out, 5);
      run_op("t2.popx", ACT_POP, 1, 0, 0);
      check("t2.popx.lit", last_err, 1);

      // Scans over {3,9,1,12}
      run_op("t3.p", ACT_PUSH, 2, 0, 3);
      run_op("t3.p", ACT_PUSH, 2, 0, 9);
      run_op("t3.p", ACT_PUSH, 2, 0, 1);
      run_op("t3.p", ACT_PUSH, 2, 0, 12);
      run_op("t3.gt4", ACT_GREATER, 2, 0, 4);
      check("t3.gt4.lit", last_out, 2);
      check("t3.gt4.latlit", last_lat, 5);
      run_op("t3.lt4", ACT_LESS, 2, 0, 4);
      check("t3.lt4.lit", last_out, 2);
      run_op("t3.lt0", ACT_LESS, 2, 0, 0);
      run_op("t3.gt255", ACT_GREATER, 2, 0, 255);
      run_op("t3.gtempty", ACT_GREATER, 6, 0, 4);
      check("t3.gtempty.latlit", last_lat, 1);

      // Write/Read with bounds
      run_op("t4.p3", ACT_PUSH, 3, 0, 3);
      run_op("t4.p9", ACT_PUSH, 3, 0, 9);
      run_op("t4.w1", ACT_WRITE, 3, 1, 6);
      run_op("t4.r1", ACT_READ, 3, 1, 0);
      check("t4.r1.lit", last_out, 6);
      run_op("t4.r2", ACT_READ, 3, 2, 0);
      check("t4.r2.errlit", last_err, 1);
      run_op("t4.w2", ACT_WRITE, 3, 2, 77);
      run_op("t4.r0", ACT_READ, 3, 0, 0);
      run_op("t4.bad", 8'd0, 3, 0, 0);

      // Randomized traffic
      for (int n = 0; n < 200; n++) begin
         int unsigned r;
         logic [7:0]  a;
         r = $urandom_range(0, 99);
         if      (r < 30) a = ACT_PUSH;
         else if (r < 40) a = ACT_POP;
         else if (r < 50) a = ACT_WRITE;
         else if (r < 65) a = ACT_READ;
         else if (r < 70) a = ACT_SIZE;
         else if (r < 73) a = ACT_CLEAR;
         else if (r < 83) a = ACT_LESS;
         else if (r < 93) a = ACT_GREATER;
         else if (r < 96) a = 8'($urandom_range(0, 1));
         else             a = 8'($urandom_range(10, 255));
         run_op("rnd", a, $urandom_range(0, NA - 1), $urandom_range(0, LEN - 1), $urandom_range(0, 255));
      end

      // Reset during a scan: no response, everything empty afterwards
      run_op("t5.clr", ACT_CLEAR, 5, 0, 0);
      for (int k = 0; k < LEN; k++) run_op("t5.p", ACT_PUSH, 5, 0, 10 + k);
      action    = ACT_GREATER;
      array     = 3'd5;
      in        = 8'd0;
      req_valid = 1'b1;
      @(posedge clock);
      #1 req_valid = 1'b0;
      seen = 0;
      repeat (2) begin
         @(posedge clock);
         #1 if (out_valid) seen++;
      end
      reset = 1'b1;
      #1;
      check("t5.ready_in_reset", req_ready, 1);
      repeat (2) begin
         @(posedge clock);
         #1 if (out_valid) seen++;
      end
      @(negedge clock);
      reset = 1'b0;
      repeat (8) begin
         @(posedge clock);
         #1 if (out_valid) seen++;
      end
      check("t5.no_response", seen, 0);
      check("t5.ready_after", req_ready, 1);
      @(negedge clock);
      for (int k = 0; k < NA; k++) model_q[k].delete();
      for (int k = 0; k < NA; k++) run_op("t5.size", ACT_SIZE, k, 0, 0);

      // Back-to-back requests with req_valid held high
      for (int k = 0; k < 14; k++) begin
         int unsigned eo;
         bit          ee;
         int          el;
         logic [7:0]  a;
         logic [7:0]  ar;
         logic [7:0]  d;
         a  = (k == 7) ? 8'd0 : ((k % 3 == 2) ? ACT_SIZE : ACT_PUSH);
         ar = 8'($urandom_range(0, 1));
         d  = 8'($urandom_range(0, 255));
         model_exec(a, int'(ar), 0, d, eo, ee, el);
         b_act.push_back(a);
         b_arr.push_back(ar);
         b_din.push_back(d);
         exp_o.push_back(eo);
         exp_e.push_back(ee);
      end
      sent = 0;
      got  = 0;
      cyc  = 0;
      while (got < 14 && cyc < 400) begin
         @(negedge clock);
         if (sent < 14) begin
            action    = b_act[sent];
            array     = b_arr[sent][AB-1:0];
            index     = '0;
            in        = b_din[sent];
            req_valid = 1'b1;
         end else begin
            req_valid = 1'b0;
         end
         acc = req_valid && req_ready;
         @(posedge clock);
         if (acc) sent++;
         #1;
         if (out_valid) begin
            if (got < 14) begin
               check("t6.out", out,   exp_o[got]);
               check("t6.err", error, exp_e[got]);
               if (got == 7) check("t6.bad.errlit", error, 1);
            end
            got++;
         end
         cyc++;
      end
      req_valid = 1'b0;
      check("t6.accepted", sent, 14);
      check("t6.responses", got, 14);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
